// File: rtl/imem_load_arbiter.sv
// imem_load_arbiter: boot sequencer (zero-fill, load, run) and fetch/loader arbiter for a single-port imem
module imem_load_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_rvalid,
    output logic [31:0]       fetch_rdata,
    output logic              fetch_misalign,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    input  logic              ld_done,
    output logic              cpu_run,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    typedef enum logic [1:0] {CLEAR, LOAD, RUN} state_e;
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;
    state_e            state_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic              lw_ld_q, pend_q, oor_q, mis_q;
    logic [31:0]       hold_q;
    logic              clr, f_in, l_in, l_wr, f_rd;
    assign f_in = 32'(fetch_addr[31:2]) < DEPTH_W;
    assign l_in = 32'(ld_addr) < DEPTH_W;
    // Handshakes are combinational so an accepted access hits the memory in the same cycle
    always_comb begin
        clr       = !rst && state_q == CLEAR;
        fetch_gnt = !rst && state_q == RUN && fetch_req && (!ld_valid || lw_ld_q);
        ld_ready  = !rst && ld_valid && (state_q == LOAD || (state_q == RUN && !(fetch_req && lw_ld_q)));
        l_wr      = ld_ready && l_in;
        f_rd      = fetch_gnt && f_in;
        mem_en    = clr || l_wr || f_rd;
        mem_we    = clr || l_wr;
        mem_addr  = clr ? clr_cnt_q : l_wr ? ld_addr : f_rd ? fetch_addr[ADDR_W+1:2] : '0;
        mem_wdata = l_wr ? ld_data : '0;
    end
    assign fetch_rvalid   = pend_q;
    assign fetch_rdata    = pend_q ? (oor_q ? NOP : mem_rdata) : hold_q;
    assign fetch_misalign = mis_q;
    assign cpu_run        = state_q == RUN;
    // lw_ld_q resets to 1 (loader won last) so fetch wins the first conflict
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            lw_ld_q   <= 1'b1;
            pend_q    <= 1'b0;
            oor_q     <= 1'b0;
            mis_q     <= 1'b0;
            hold_q    <= '0;
        end else begin
            if (state_q == CLEAR) begin
                clr_cnt_q <= (32'(clr_cnt_q) == DEPTH_W - 32'd1) ? '0 : clr_cnt_q + ADDR_W'(1);
                if (32'(clr_cnt_q) == DEPTH_W - 32'd1) state_q <= LOAD;
            end
            if (state_q == LOAD && ld_done) state_q <= RUN;
            if (state_q == RUN && fetch_req && ld_valid) lw_ld_q <= ld_ready;
            pend_q <= fetch_gnt;
            oor_q  <= !f_in;
            if (pend_q) hold_q <= fetch_rdata;
            if (fetch_gnt && fetch_addr[1:0] != 2'b00) mis_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_imem_load_arbiter.sv
// tb_imem_load_arbiter: randomized check of boot sequencing, fetch service and arbitration against a word-array model
module tb_imem_load_arbiter;
    localparam int AW = 8;
    localparam int D = 256;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic clk = 0;
    logic rst = 1;
    logic fetch_req = 0;
    logic [31:0] fetch_addr = 0;
    logic fetch_gnt, fetch_rvalid, fetch_misalign;
    logic [31:0] fetch_rdata;
    logic ld_valid = 0;
    logic ld_ready;
    logic [AW-1:0] ld_addr = 0;
    logic [31:0] ld_data = 0;
    logic ld_done = 0;
    logic cpu_run, mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [31:0] ram [D];
    logic [31:0] gold [D];
    logic [78:0] all_o;
    bit fetch_first = 1;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    imem_load_arbiter #(.ADDR_W(AW), .DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .fetch_misalign(fetch_misalign),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_done(ld_done), .cpu_run(cpu_run),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    assign all_o = {fetch_gnt, fetch_rvalid, fetch_rdata, fetch_misalign, ld_ready, cpu_run,
                    mem_en, mem_we, mem_addr, mem_wdata};

    // Synchronous-read RAM; scrambled while in reset so the zero-fill is observable
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < D; i++) ram[i] <= 32'hDEAD_0000 | i;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else mem_rdata <= ram[mem_addr];
        end
    end

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        return (a >> 2) >= D ? NOP : gold[a[AW+1:2]];
    endfunction

    task automatic ld_once(input logic [AW-1:0] a, input logic [31:0] d, output logic r, output logic e);
        ld_valid = 1; ld_addr = a; ld_data = d;
        #1 r = ld_ready; e = mem_en && mem_we && mem_addr == a && mem_wdata == d;
        @(negedge clk); ld_valid = 0;
    endtask

    task automatic fetch_once(input logic [31:0] a, output logic g, output logic [AW+1:0] ma,
                              output logic v, output logic [31:0] d);
        fetch_req = 1; fetch_addr = a;
        #1 g = fetch_gnt; ma = {mem_en, mem_we, mem_addr};
        @(negedge clk); fetch_req = 0;
        #1 v = fetch_rvalid; d = fetch_rdata;
        @(negedge clk);
    endtask

    task automatic test_reset();
        fetch_req = 1; ld_valid = 1; ld_done = 1;
        #1 total++;
        if (all_o !== '0) begin bad++; $display("FAIL reset_t0 outputs=%h want 0", all_o); end
        @(negedge clk); #1 total++;
        if (all_o !== '0) begin bad++; $display("FAIL reset_held outputs=%h want 0", all_o); end
        fetch_req = 0; ld_valid = 0; ld_done = 0;
        @(negedge clk);
    endtask

    task automatic test_clear(input int n);
        int errs, first;
        logic r, e;
        logic [31:0] d;
        errs = 0; first = -1;
        for (int i = 0; i < D; i++) gold[i] = 0;
        fetch_first = 1;
        rst = 0; fetch_req = 1; ld_valid = 0;
        for (int i = 0; i < n; i++) begin
            ld_done = 1'($urandom_range(0, 1));
            #1;
            if (!(mem_en === 1 && mem_we === 1 && mem_addr === AW'(i) && mem_wdata === 0 &&
                  ld_ready === 0 && fetch_gnt === 0 && cpu_run === 0)) begin
                errs++; if (first < 0) first = i;
            end
            @(negedge clk);
        end
        ld_done = 0;
        total++;
        if (errs !== 0) begin bad++; $display("FAIL clear_seq bad_cycles=%0d first=%0d want 0", errs, first); end
        if (n == D) begin
            #1 total++;
            if (mem_en !== 0 || fetch_gnt !== 0 || cpu_run !== 0 || ld_ready !== 0) begin
                bad++; $display("FAIL load_idle en=%b gnt=%b run=%b rdy=%b want 0000", mem_en, fetch_gnt, cpu_run, ld_ready);
            end
            fetch_req = 0; d = $urandom;
            ld_once(7, d, r, e);
            total++;
            if (!(r && e)) begin bad++; $display("FAIL load_ready rdy=%b wr=%b want 1 1", r, e); end
            gold[7] = d;
        end
    endtask

    task automatic test_load();
        logic r, e, g, v;
        logic [AW+1:0] ma;
        logic [31:0] d;
        logic [31:0] fa [4];
        ld_once(1, 32'h4030_82B3, r, e); gold[1] = 32'h4030_82B3;
        total++; if (!(r && e)) begin bad++; $display("FAIL ld_w1 rdy=%b wr=%b want 1 1", r, e); end
        ld_once(2, 32'h002A_8B13, r, e); gold[2] = 32'h002A_8B13;
        total++; if (!(r && e)) begin bad++; $display("FAIL ld_w2 rdy=%b wr=%b want 1 1", r, e); end
        total++; if (cpu_run !== 0) begin bad++; $display("FAIL run_early cpu_run=%b want 0", cpu_run); end
        d = $urandom; ld_done = 1;
        ld_once(9, d, r, e); ld_done = 0; gold[9] = d;
        total++; if (!(r && e)) begin bad++; $display("FAIL ld_with_done rdy=%b wr=%b want 1 1", r, e); end
        #1 total++;
        if (cpu_run !== 1) begin bad++; $display("FAIL run_late cpu_run=%b want 1", cpu_run); end
        @(negedge clk);
        fa = '{32'h4, 32'h8, 32'h0, 32'h24};
        foreach (fa[i]) begin
            fetch_once(fa[i], g, ma, v, d);
            total++;
            if (!(g && v && ma === {2'b10, fa[i][AW+1:2]}) || d !== exp_word(fa[i]))
                begin bad++; $display("FAIL fetch_%h gnt=%b mem=%h rv=%b data=%h want %h", fa[i], g, ma, v, d, exp_word(fa[i])); end
        end
    endtask

    task automatic test_conflict();
        logic pend, fw;
        logic [31:0] pexp;
        pend = 0; pexp = 0;
        fetch_req = 1; ld_valid = 1; fetch_addr = 32'h10; ld_addr = 20; ld_data = $urandom;
        for (int c = 0; c < 4; c++) begin
            #1 fw = (c % 2 == 0);
            total++;
            if (fetch_gnt !== fw || ld_ready !== !fw)
                begin bad++; $display("FAIL conflict_%0d gnt=%b rdy=%b want %b %b", c, fetch_gnt, ld_ready, fw, !fw); end
            total++;
            if (fetch_rvalid !== pend || (pend && fetch_rdata !== pexp))
                begin bad++; $display("FAIL conflict_rd_%0d rv=%b data=%h want %b %h", c, fetch_rvalid, fetch_rdata, pend, pexp); end
            pend = fw;
            if (fw) pexp = exp_word(fetch_addr); else gold[ld_addr] = ld_data;
            fetch_first = !fetch_first;
            @(negedge clk);
            if (fw) fetch_addr = fetch_addr + 4;
            else begin ld_addr = ld_addr + AW'(1); ld_data = $urandom; end
        end
        fetch_req = 0; ld_valid = 0;
        #1 total++;
        if (fetch_rvalid !== pend || fetch_rdata !== pexp)
            begin bad++; $display("FAIL conflict_rd_last rv=%b data=%h want %b %h", fetch_rvalid, fetch_rdata, pend, pexp); end
        @(negedge clk);
    endtask

    task automatic test_raw();
        logic r, e, g, v;
        logic [AW+1:0] ma;
        logic [31:0] d, q;
        d = $urandom;
        ld_once(5, d, r, e); gold[5] = d;
        fetch_once(32'h14, g, ma, v, q);
        total++;
        if (!(r && e && g && v) || q !== d)
            begin bad++; $display("FAIL raw rdy=%b gnt=%b rv=%b data=%h want %h", r, g, v, q, d); end
    endtask

    task automatic test_random();
        logic ef, el, pend;
        logic [31:0] pexp;
        ef = 0; el = 0; pend = 0; pexp = 0;
        for (int c = 0; c < 300; c++) begin
            if (!(fetch_req && !ef)) begin
                fetch_req = ($urandom_range(0, 2) != 0);
                fetch_addr = ($urandom_range(0, 9) == 0) ? 32'(D + $urandom_range(0, 3)) << 2
                                                         : 32'($urandom_range(0, 31)) << 2;
            end
            if (!(ld_valid && !el)) begin
                ld_valid = ($urandom_range(0, 2) == 0);
                ld_addr = AW'($urandom_range(0, 15));
                ld_data = $urandom;
            end
            #1;
            ef = fetch_req && (!ld_valid || fetch_first);
            el = ld_valid && !ef;
            total++;
            if (fetch_gnt !== ef || ld_ready !== el || (ef && mem_en !== ((fetch_addr >> 2) < D)))
                begin bad++; $display("FAIL rnd_arb c=%0d gnt=%b rdy=%b en=%b want gnt=%b rdy=%b", c, fetch_gnt, ld_ready, mem_en, ef, el); end
            total++;
            if (fetch_rvalid !== pend || (pend && fetch_rdata !== pexp))
                begin bad++; $display("FAIL rnd_rd c=%0d rv=%b data=%h want %b %h", c, fetch_rvalid, fetch_rdata, pend, pexp); end
            if (fetch_req && ld_valid) fetch_first = !fetch_first;
            pend = ef;
            if (ef) pexp = exp_word(fetch_addr);
            if (el) gold[ld_addr] = ld_data;
            @(negedge clk);
        end
        fetch_req = 0; ld_valid = 0;
        #1 total++;
        if (fetch_rvalid !== pend || (pend && fetch_rdata !== pexp))
            begin bad++; $display("FAIL rnd_rd_last rv=%b data=%h want %b %h", fetch_rvalid, fetch_rdata, pend, pexp); end
        @(negedge clk);
    endtask

    task automatic test_oor_misalign();
        logic g, v;
        logic [AW+1:0] ma;
        logic [31:0] d;
        fetch_once(32'h400, g, ma, v, d);
        total++;
        if (!g || ma[AW+1] !== 0 || !v || d !== NOP)
            begin bad++; $display("FAIL oor gnt=%b en=%b rv=%b data=%h want 1 0 1 %h", g, ma[AW+1], v, d, NOP); end
        #1 total++;
        if (fetch_rvalid !== 0 || fetch_rdata !== NOP)
            begin bad++; $display("FAIL rdata_hold rv=%b data=%h want 0 %h", fetch_rvalid, fetch_rdata, NOP); end
        total++;
        if (fetch_misalign !== 0) begin bad++; $display("FAIL mis_early misalign=%b want 0", fetch_misalign); end
        @(negedge clk);
        fetch_once(32'h6, g, ma, v, d);
        total++;
        if (!g || !v || ma !== {2'b10, AW'(1)} || d !== exp_word(32'h4) || fetch_misalign !== 1)
            begin bad++; $display("FAIL misalign gnt=%b rv=%b data=%h mis=%b want %h mis=1", g, v, d, fetch_misalign, exp_word(32'h4)); end
        fetch_once(32'h8, g, ma, v, d);
        total++;
        if (!g || !v || d !== exp_word(32'h8) || fetch_misalign !== 1)
            begin bad++; $display("FAIL mis_sticky data=%h mis=%b want %h mis=1", d, fetch_misalign, exp_word(32'h8)); end
    endtask

    task automatic test_reset_mid();
        fetch_req = 1; fetch_addr = 32'h4;
        @(negedge clk); fetch_req = 0;
        #2 rst = 1;
        #1 total++;
        if (all_o !== '0) begin bad++; $display("FAIL rst_run outputs=%h want 0", all_o); end
        @(negedge clk); total++;
        if (all_o !== '0) begin bad++; $display("FAIL rst_run_held outputs=%h want 0", all_o); end
        test_clear(100);
        #1 total++;
        if (mem_addr !== AW'(100) || mem_we !== 1) begin bad++; $display("FAIL clr_100 addr=%0d we=%b want 100 1", mem_addr, mem_we); end
        rst = 1;
        #1 total++;
        if (all_o !== '0) begin bad++; $display("FAIL rst_clear outputs=%h want 0", all_o); end
        @(negedge clk);
        test_clear(D);
        ld_valid = 1; ld_addr = 3; ld_data = $urandom;
        #1 total++;
        if (ld_ready !== 1 || mem_en !== 1) begin bad++; $display("FAIL mid_load rdy=%b en=%b want 1 1", ld_ready, mem_en); end
        rst = 1;
        #1 total++;
        if (all_o !== '0) begin bad++; $display("FAIL rst_load outputs=%h want 0", all_o); end
        @(negedge clk); ld_valid = 0;
        test_clear(D);
    endtask

    initial begin
        test_reset();
        test_clear(D);
        test_load();
        test_conflict();
        test_raw();
        test_random();
        test_oor_misalign();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
